// File: rtl/fila_bytes.sv
// rtl/fila_bytes.sv - byte FIFO between the deserializer and the consumer.
// Input side uses a data_ready/ack handshake; output side pops one byte per dequeue.
module fila_bytes #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_100KHz,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_ready_in,
  output logic                       ack_out,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACK      = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  logic [1:0]       state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  // Both decisions use the count before this edge's update.
  assign wr_en = (state == IDLE) && data_ready_in && (count < CW'(DEPTH));
  assign rd_en = dequeue_in && (count != '0);

  assign ack_out   = (state == ACK);
  assign len_out   = count;
  assign full_out  = (count == CW'(DEPTH));
  assign empty_out = (count == '0);

  always_ff @(posedge clk_100KHz) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE:     if (wr_en) state <= ACK;
        ACK:      state <= WAIT_LOW;
        WAIT_LOW: if (!data_ready_in) state <= IDLE;
        default:  state <= IDLE;
      endcase

      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      if (rd_en) begin
        data_out  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end

      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fila_bytes.sv
// tb/tb_fila_bytes.sv - directed self-checking bench for fila_bytes.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_fila_bytes;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_ready_in;
  logic       ack_out;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic [3:0] len_out;
  logic       full_out;
  logic       empty_out;

  int n_checks = 0;
  int n_fail   = 0;

  fila_bytes #(.DEPTH(8), .WIDTH(8)) dut (
    .clk_100KHz    (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_ready_in (data_ready_in),
    .ack_out       (ack_out),
    .dequeue_in    (dequeue_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .len_out       (len_out),
    .full_out      (full_out),
    .empty_out     (empty_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full handshake: wait for ack, confirm it lasts one cycle, then drop data_ready_in.
  task automatic put_byte(input logic [7:0] b);
    int waited = 0;
    data_in       = b;
    data_ready_in = 1'b1;
    while (!ack_out && waited < 20) begin
      tick();
      waited++;
    end
    check("ack_seen", {31'd0, ack_out}, 32'd1);
    tick();
    check("ack_one_cycle", {31'd0, ack_out}, 32'd0);
    data_ready_in = 1'b0;
    tick();
  endtask

  task automatic get_byte(input logic [7:0] exp);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    check("get_valid", {31'd0, valid_out}, 32'd1);
    check("get_data", {24'd0, data_out}, {24'd0, exp});
  endtask

  initial begin
    reset         = 1'b0;
    data_in       = 8'h00;
    data_ready_in = 1'b0;
    dequeue_in    = 1'b0;

    // Reset then idle
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst_ack", {31'd0, ack_out}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_len", {28'd0, len_out}, 32'd0);
    check("rst_empty", {31'd0, empty_out}, 32'd1);
    check("rst_full", {31'd0, full_out}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);

    // Single byte
    put_byte(8'hA5);
    check("single_len", {28'd0, len_out}, 32'd1);
    get_byte(8'hA5);
    check("single_len0", {28'd0, len_out}, 32'd0);
    check("single_empty", {31'd0, empty_out}, 32'd1);

    // Fill to full, then backpressure
    for (int i = 1; i <= 8; i++) put_byte(8'(i));
    check("fill_full", {31'd0, full_out}, 32'd1);
    check("fill_len", {28'd0, len_out}, 32'd8);
    data_in       = 8'h09;
    data_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_ack", {31'd0, ack_out}, 32'd0);
      check("full_len", {28'd0, len_out}, 32'd8);
    end
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    check("full_deq_valid", {31'd0, valid_out}, 32'd1);
    check("full_deq_data", {24'd0, data_out}, 32'h01);
    check("full_deq_len", {28'd0, len_out}, 32'd7);
    check("full_deq_noack", {31'd0, ack_out}, 32'd0);
    tick();
    check("late_ack", {31'd0, ack_out}, 32'd1);
    check("late_full", {31'd0, full_out}, 32'd1);
    tick();
    data_ready_in = 1'b0;
    tick();
    for (int i = 2; i <= 9; i++) get_byte(8'(i));
    check("drain_empty", {31'd0, empty_out}, 32'd1);

    // Wrap-around
    for (int i = 0; i < 6; i++) put_byte(8'h20 + 8'(i));
    for (int i = 0; i < 6; i++) get_byte(8'h20 + 8'(i));
    for (int i = 0; i < 8; i++) put_byte(8'h10 + 8'(i));
    check("wrap_full", {31'd0, full_out}, 32'd1);
    dequeue_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("wrap_valid", {31'd0, valid_out}, 32'd1);
      check("wrap_data", {24'd0, data_out}, {24'd0, 8'h10 + 8'(i)});
    end
    tick();
    check("empty_deq_valid", {31'd0, valid_out}, 32'd0);
    check("empty_deq_hold", {24'd0, data_out}, 32'h17);
    check("empty_deq_len", {28'd0, len_out}, 32'd0);
    dequeue_in = 1'b0;

    // Simultaneous write and dequeue at len 3
    put_byte(8'h30);
    put_byte(8'h31);
    put_byte(8'h32);
    data_in       = 8'h33;
    data_ready_in = 1'b1;
    dequeue_in    = 1'b1;
    tick();
    dequeue_in = 1'b0;
    check("sim_valid", {31'd0, valid_out}, 32'd1);
    check("sim_data", {24'd0, data_out}, 32'h30);
    check("sim_len", {28'd0, len_out}, 32'd3);
    check("sim_ack", {31'd0, ack_out}, 32'd1);
    tick();
    data_ready_in = 1'b0;
    tick();
    get_byte(8'h31);
    get_byte(8'h32);
    get_byte(8'h33);
    check("sim_empty", {31'd0, empty_out}, 32'd1);

    // Empty + write + dequeue on the same edge
    data_in       = 8'h40;
    data_ready_in = 1'b1;
    dequeue_in    = 1'b1;
    tick();
    dequeue_in = 1'b0;
    check("ew_valid", {31'd0, valid_out}, 32'd0);
    check("ew_len", {28'd0, len_out}, 32'd1);
    check("ew_ack", {31'd0, ack_out}, 32'd1);
    tick();
    data_ready_in = 1'b0;
    tick();
    get_byte(8'h40);

    // Reset during ACK with len 4
    put_byte(8'h50);
    put_byte(8'h51);
    put_byte(8'h52);
    data_in       = 8'h53;
    data_ready_in = 1'b1;
    tick();
    check("mid_ack", {31'd0, ack_out}, 32'd1);
    check("mid_len", {28'd0, len_out}, 32'd4);
    #1 reset = 1'b0;
    #1;
    check("arst_ack", {31'd0, ack_out}, 32'd0);
    check("arst_len", {28'd0, len_out}, 32'd0);
    check("arst_empty", {31'd0, empty_out}, 32'd1);
    data_ready_in = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    put_byte(8'h60);
    check("post_len", {28'd0, len_out}, 32'd1);
    get_byte(8'h60);
    check("post_empty", {31'd0, empty_out}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fila_bytes.md
Name: fila_bytes

Overview:
- Byte queue directly downstream of the serial-to-byte deserializer stage.
- Accepts each completed byte via a data_ready/ack handshake: one ack pulse per byte, then waits for data_ready to fall.
- Stores bytes in a circular FIFO and releases them to the consumer, one byte per dequeue request.
- Applies backpressure by withholding ack when full, which holds the deserializer in its send state.

Parameters:
- DEPTH, 8, number of byte slots; must be a power of 2, at least 2.
- WIDTH, 8, data width in bits.

Ports:
- clk_100KHz  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  WIDTH  byte from deserializer; valid while data_ready_in=1.
- data_ready_in  input  1  deserializer byte-available flag.
- ack_out  output  1  one-cycle acknowledge pulse to deserializer.
- dequeue_in  input  1  consumer request; sampled every cycle while high.
- data_out  output  WIDTH  dequeued byte; holds last value until next dequeue.
- valid_out  output  1  one-cycle pulse when data_out is updated.
- len_out  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full_out  output  1  len_out == DEPTH.
- empty_out  output  1  len_out == 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - ack_out=0, valid_out=0, data_out=0, len_out=0, empty_out=1, full_out=0.
  - Read and write pointers = 0; input FSM = IDLE.
  - Memory contents need not be cleared.
  - Reset asserted mid-handshake or mid-dequeue aborts the operation and discards all stored bytes.
- Storage:
  - Circular buffer, write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits.
  - Pointers wrap from DEPTH-1 to 0 naturally.
  - Separate count register drives len_out.
  - full_out and empty_out are derived from count, not from pointer comparison.
- Input FSM (registered), states IDLE, ACK, WAIT_LOW:
  - IDLE: if data_ready_in=1 and count<DEPTH: mem[wr_ptr]<=data_in, wr_ptr++, go to ACK. Otherwise stay; ack_out=0.
  - IDLE while full: no capture, no ack. Byte is taken on the first edge where count<DEPTH.
  - ACK: ack_out=1 for exactly this one cycle, then go to WAIT_LOW unconditionally.
  - WAIT_LOW: ack_out=0. Stay while data_ready_in=1; go to IDLE on the edge data_ready_in=0 is seen. This prevents double capture of one byte.
  - ack_out is a registered output, high exactly when state==ACK.
  - Latency: byte written on edge N (data_ready_in seen), ack_out high during cycle N+1, earliest next capture edge N+3.
- Output side:
  - On an edge with dequeue_in=1 and count>0: data_out<=mem[rd_ptr], rd_ptr++, valid_out<=1.
  - Otherwise valid_out<=0 and data_out holds its value.
  - Dequeue when empty is ignored: no pointer change, valid_out=0, data_out unchanged.
  - A continuously high dequeue_in drains one byte per cycle.
- Count update per edge:
  - +1 on write only.
  - -1 on dequeue only.
  - Unchanged when both occur in the same edge.
- Simultaneous events:
  - Full + dequeue + pending write: only the dequeue happens this edge (the write decision uses count before the update). Write happens the next edge.
  - Empty + write + dequeue same edge: dequeue is ignored (count was 0). Byte is available from the next edge.
- Count never exceeds DEPTH and never underflows.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> ack_out=0, valid_out=0, len_out=0, empty_out=1, full_out=0, data_out=0.
- Single byte: data_in=8'hA5, data_ready_in=1 until one cycle after ack_out pulse -> ack_out high exactly 1 cycle, len_out=1; then dequeue_in=1 for one cycle -> valid_out pulse, data_out=8'hA5, len_out=0, empty_out=1.
- Fill to full (DEPTH=8): write 8'h01..8'h08 -> full_out=1, len_out=8; present 8'h09 -> no ack_out while full. One dequeue returns 8'h01; 8'h09 is captured within 2 cycles, ack pulses, full_out=1 again.
- Wrap-around: write 6, read 6, write 8 (8'h10..8'h17), read 8 -> output order 8'h10..8'h17 with no loss or duplication.
- Simultaneous write and dequeue at len_out=3 -> len_out stays 3; dequeued byte is the oldest; the new byte appears last. Dequeue at empty -> valid_out stays 0.
- Reset mid-handshake: assert reset during ACK state with len_out=4 -> ack_out=0 immediately, len_out=0, empty_out=1; a subsequent byte transfer works normally.
